// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register: captures a word on load and presents
// it MSB-first on serial_out, one bit per clock, with busy/last_bit status.
module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             busy,
    output logic             last_bit
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);
    localparam logic [CW-1:0] ONE        = CW'(1);

    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bits_left;

    // Load wins over shifting; shifting never stops, so an idle register drains to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bits_left <= '0;
        end else if (load) begin
            shift_reg <= parallel_in;
            bits_left <= FULL_COUNT;
        end else begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            if (bits_left != '0) begin
                bits_left <= bits_left - ONE;
            end
        end
    end

    assign serial_out = shift_reg[WIDTH-1];
    assign busy       = (bits_left != '0);
    assign last_bit   = (bits_left == ONE);

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed self-checking bench for piso_shift_reg (WIDTH=4): reset, single word,
// idle drain, reset-then-load, mid-word reload, held load and back-to-back words.
module tb_piso_shift_reg;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] parallel_in;
    logic       serial_out;
    logic       busy;
    logic       last_bit;

    int tests_run = 0;
    int tests_failed = 0;

    piso_shift_reg #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .parallel_in (parallel_in),
        .serial_out  (serial_out),
        .busy        (busy),
        .last_bit    (last_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load = 1'b0;
        parallel_in = 4'b0000;
        #2;
        tests_run++;
        if (serial_out !== 1'b0 || busy !== 1'b0 || last_bit !== 1'b0 || dut.shift_reg !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_pre_edge: got so=%b busy=%b last=%b sr=%b expected 0 0 0 0000",
                     serial_out, busy, last_bit, dut.shift_reg);
        end
        tick();
        tick();
        tests_run++;
        if (serial_out !== 1'b0 || busy !== 1'b0 || last_bit !== 1'b0 || dut.shift_reg !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_held: got so=%b busy=%b last=%b sr=%b expected 0 0 0 0000",
                     serial_out, busy, last_bit, dut.shift_reg);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_word();
        logic [3:0] word;
        word = 4'b1101;
        rst = 1'b0;
        parallel_in = word;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (serial_out !== word[3-k] || busy !== 1'b1 || last_bit !== (k == 3)) begin
                tests_failed++;
                $display("FAIL single_bit%0d: got so=%b busy=%b last=%b expected so=%b busy=1 last=%b",
                         k, serial_out, busy, last_bit, word[3-k], (k == 3));
            end
            tick();
        end
        tests_run++;
        if (serial_out !== 1'b0 || busy !== 1'b0 || last_bit !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: got so=%b busy=%b last=%b expected 0 0 0",
                     serial_out, busy, last_bit);
        end
        $display("[TB] test_single_word done");
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (serial_out !== 1'b0 || busy !== 1'b0 || dut.shift_reg !== 4'b0000) begin
                tests_failed++;
                $display("FAIL idle_%0d: got so=%b busy=%b sr=%b expected 0 0 0000",
                         i, serial_out, busy, dut.shift_reg);
            end
        end
        $display("[TB] test_idle done");
    endtask

    task automatic test_async_mid_word();
        parallel_in = 4'b1111;
        load = 1'b1;
        tick();
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (serial_out !== 1'b0 || busy !== 1'b0 || dut.shift_reg !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_mid_word: got so=%b busy=%b sr=%b expected 0 0 0000",
                     serial_out, busy, dut.shift_reg);
        end
        tick();
        $display("[TB] test_async_mid_word done");
    endtask

    task automatic test_reset_then_load();
        logic [3:0] word;
        word = 4'b1101;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load = 1'b1;
        parallel_in = word;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (serial_out !== word[3-k] || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL rst_load_bit%0d: got so=%b busy=%b expected so=%b busy=1",
                         k, serial_out, busy, word[3-k]);
            end
            tick();
        end
        $display("[TB] test_reset_then_load done");
    endtask

    task automatic test_reload();
        logic [5:0] stream;
        stream = 6'b10_0111;
        parallel_in = 4'b1010;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (serial_out !== stream[5-k] || busy !== 1'b1 || last_bit !== (k == 5)) begin
                tests_failed++;
                $display("FAIL reload_bit%0d: got so=%b busy=%b last=%b expected so=%b busy=1 last=%b",
                         k, serial_out, busy, last_bit, stream[5-k], (k == 5));
            end
            if (k == 1) begin
                parallel_in = 4'b0111;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        tests_run++;
        if (busy !== 1'b0 || serial_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reload_done: got so=%b busy=%b expected 0 0", serial_out, busy);
        end
        $display("[TB] test_reload done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] stream;
        stream = 8'b1000_0001;
        parallel_in = 4'b1000;
        load = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick();
            tests_run++;
            if (serial_out !== 1'b1 || busy !== 1'b1 || last_bit !== 1'b0 || dut.shift_reg !== 4'b1000) begin
                tests_failed++;
                $display("FAIL held_load_%0d: got so=%b busy=%b last=%b sr=%b expected 1 1 0 1000",
                         h, serial_out, busy, last_bit, dut.shift_reg);
            end
        end
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (serial_out !== stream[7-i] || busy !== 1'b1 || last_bit !== (i == 3 || i == 7)) begin
                tests_failed++;
                $display("FAIL b2b_bit%0d: got so=%b busy=%b last=%b expected so=%b busy=1 last=%b",
                         i, serial_out, busy, last_bit, stream[7-i], (i == 3 || i == 7));
            end
            if (i == 3) begin
                parallel_in = 4'b0001;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        tests_run++;
        if (serial_out !== 1'b0 || busy !== 1'b0 || last_bit !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_done: got so=%b busy=%b last=%b expected 0 0 0",
                     serial_out, busy, last_bit);
        end
        $display("[TB] test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_idle();
        test_async_mid_word();
        test_reset_then_load();
        test_reload();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parallel-in, serial-out shift register for the `piso_shift_register` design unit. It captures a WIDTH-bit parallel word on `load` and then shifts it out MSB-first, one bit per clock. It sits between a word-wide producer and a single-wire serial consumer. Two status flags let the surrounding logic tell when a word is in flight and when its final bit is on the line.

## Interface
- `WIDTH`, default 4: parallel word width; minimum 2.
- `clk` input, 1 bit: rising-edge clock, the only clock in the block.
- `rst` input, 1 bit: asynchronous reset, active-high.
- `load` input, 1 bit: capture `parallel_in` on the next rising edge.
- `parallel_in` input, WIDTH bits: word to serialize.
- `serial_out` output, 1 bit: current serial bit, equal to `shift_reg[WIDTH-1]`.
- `busy` output, 1 bit: high while loaded bits remain to be presented.
- `last_bit` output, 1 bit: high while the final bit of a loaded word is on `serial_out`.

## Operation
- The internal data register is named `shift_reg` (WIDTH bits). Benches probe it hierarchically, so the name is fixed.
- A bit counter `bits_left` (0..WIDTH) sizes itself with `$clog2(WIDTH+1)`.
- Reset (`rst`=1, asynchronous, held as long as asserted):
  - `shift_reg` = 0 and `bits_left` = 0.
  - Outputs therefore read `serial_out`=0, `busy`=0, `last_bit`=0.
- On each rising edge with `rst`=0, priority is top-down:
  - `load`=1: `shift_reg` <= `parallel_in` and `bits_left` <= WIDTH.
  - Otherwise: `shift_reg` <= {`shift_reg[WIDTH-2:0]`, 1'b0}, and `bits_left` decrements if nonzero (saturates at 0).
- Shifting is free-running. There is no shift enable, and the register keeps shifting zeros when idle.
- `serial_out` = `shift_reg[WIDTH-1]`, driven straight from a flop with no combinational path from inputs.
- `busy` = (`bits_left` != 0).
- `last_bit` = (`bits_left` == 1).
- Boundary cases:
  - `load` while `busy`: the current word is abandoned and the new word starts immediately.
  - `load` held high for several cycles: the word is reloaded every edge, so the MSB stays on `serial_out` and no shifting occurs.
  - `rst` mid-word: the word is lost and all state clears at once.
  - `rst` deasserted in the same cycle that `load` is raised: the load takes effect on the first rising edge after `rst` falls.

## Timing
- Load latency: the MSB `parallel_in[WIDTH-1]` appears on `serial_out` right after the capturing edge.
- Bit k (counted from MSB, k=0..WIDTH-1) is valid from edge k after the load edge until the next edge.
- A word occupies exactly WIDTH cycles.
- `busy` rises with the load edge and falls after edge WIDTH.
- `last_bit` is high for exactly one cycle, aligned with bit `parallel_in[0]`.
- After the word completes, `serial_out` = 0 until the next load.
- Back-to-back words: assert `load` in the cycle where `last_bit`=1. The next word's MSB then follows the previous LSB with no gap.

## Structure
- No shared package is needed. WIDTH is the only constant, and the counter width is derived locally.
- Implement as a single flat module with no sub-modules: one always block for the async reset/load/shift, and continuous assigns for the outputs.

## Test plan
- Reset: `rst`=1 with `parallel_in`=4'b0000 → `serial_out`=0, `busy`=0, `shift_reg`=0, including between edges (confirms asynchronous reset).
- Single word: release reset, `parallel_in`=4'b1101, pulse `load` for one cycle → `serial_out` = 1,1,0,1 on consecutive cycles, then 0.
  - `busy` high for 4 cycles.
  - `last_bit` high only during the 4th bit.
- Idle after word: run 4 more cycles with no load → `serial_out`=0, `shift_reg`=0, `busy`=0.
- Reset then immediate load:
  - `rst`=1 for one cycle.
  - Then `rst`=0 together with `load`=1 and `parallel_in`=4'b1101.
  - Required response: the sequence 1,1,0,1 restarts from the first post-reset edge.
- Reload mid-word: load 4'b1010, and after 2 bits load 4'b0111 → `serial_out` = 1,0 then 0,1,1,1, with `busy` continuous.
- Held load and back-to-back:
  - Holding `load`=1 with 4'b1000 for 3 cycles → `serial_out` stays 1.
  - Loading 4'b0001 in the `last_bit` cycle of a previous word → a gapless 8-bit stream.
